// File: rtl/demux8to1_16b_buf.sv
// ============================================================================
// Module   : demux8to1_16b_buf
// Brief    : Buffered 1-to-8 word distributor with per-slot valid/ack holding
//            registers; select codes 110/111 discard and bump a drop counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux8to1_16b_buf #(
  parameter int WIDTH = 16,
  parameter int NSLOT = 8,
  parameter int DROPW = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [2:0]             in_sel,
  output logic [NSLOT*WIDTH-1:0] out_data,
  output logic [NSLOT-1:0]       out_valid,
  input  logic [NSLOT-1:0]       out_ack,
  output logic [DROPW-1:0]       drop_count
);

  localparam int         c_NLIVE         = 6;
  localparam logic [2:0] c_FIRST_DISCARD = 3'd6;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  logic w_discard;
  logic w_accept;

  assign w_discard = (in_sel >= c_FIRST_DISCARD);
  // A full slot can still take a word in the same cycle its consumer drains it.
  assign in_ready  = w_discard | ~out_valid[in_sel] | out_ack[in_sel];
  assign w_accept  = in_valid & in_ready;

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    if (k < c_NLIVE) begin : g_live
      slot_state_t      r_state;
      logic [WIDTH-1:0] r_data;
      logic             w_load;

      assign w_load = w_accept & (in_sel == 3'(k));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_state <= S_EMPTY;
          r_data  <= '0;
        end else begin
          case (r_state)
            S_EMPTY: begin
              if (w_load) begin
                r_state <= S_FULL;
                r_data  <= in_data;
              end
            end
            S_FULL: begin
              if (w_load) begin
                r_data <= in_data;
              end else if (out_ack[k]) begin
                r_state <= S_EMPTY;
              end
            end
            default: r_state <= S_EMPTY;
          endcase
        end
      end

      assign out_valid[k]                 = (r_state == S_FULL);
      assign out_data[k*WIDTH +: WIDTH]   = r_data;
    end else begin : g_unused
      assign out_valid[k]                 = 1'b0;
      assign out_data[k*WIDTH +: WIDTH]   = '0;
    end
  end

  logic [DROPW-1:0] r_drop_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (w_accept && w_discard && (r_drop_count != {DROPW{1'b1}})) begin
      r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign drop_count = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_demux8to1_16b_buf.sv
// ============================================================================
// Module   : tb_demux8to1_16b_buf
// Brief    : Directed self-checking bench for demux8to1_16b_buf.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux8to1_16b_buf;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic [2:0]   in_sel;
  logic [127:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ack;
  logic [7:0]   drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  demux8to1_16b_buf dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ready_bad;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_sel   = '0;
    out_ack  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(out_valid), 128'h0);
    check("rst_data",  out_data, 128'h0);
    check("rst_drop",  128'(drop_count), 128'h0);
    reset = 1'b0;
    tick();

    // Route BEEF to slot 2
    in_valid = 1'b1; in_sel = 3'd2; in_data = 16'hBEEF;
    #1 check("route_ready", 128'(in_ready), 128'h1);
    tick();
    in_valid = 1'b0;
    check("route_valid", 128'(out_valid), 128'h04);
    check("route_data",  out_data, {80'h0, 16'hBEEF, 32'h0});
    check("route_drop",  128'(drop_count), 128'h0);

    // Backpressure on full slot 2
    in_valid = 1'b1; in_sel = 3'd2; in_data = 16'h1234;
    #1 check("bp_ready0", 128'(in_ready), 128'h0);
    tick();
    check("bp_hold", out_data, {80'h0, 16'hBEEF, 32'h0});
    check("bp_valid", 128'(out_valid), 128'h04);
    out_ack = 8'h01;
    #1 check("bp_other_ack_ready", 128'(in_ready), 128'h0);
    out_ack = 8'h04;
    #1 check("bp_ack_ready", 128'(in_ready), 128'h1);
    tick();
    in_valid = 1'b0; out_ack = 8'h00;
    check("bp_replace", out_data, {80'h0, 16'h1234, 32'h0});
    check("bp_valid_kept", 128'(out_valid), 128'h04);

    // Drain then ack empty slot
    out_ack = 8'h04;
    tick();
    check("drain_valid", 128'(out_valid), 128'h0);
    check("drain_data",  out_data, {80'h0, 16'h1234, 32'h0});
    tick();
    out_ack = 8'h00;
    check("ack_empty_valid", 128'(out_valid), 128'h0);
    check("ack_empty_data",  out_data, {80'h0, 16'h1234, 32'h0});
    in_sel = 3'd2;
    #1 check("empty_ready", 128'(in_ready), 128'h1);

    // Discard codes, saturating drop counter
    ready_bad = 0;
    in_valid = 1'b1; in_data = 16'h5A5A;
    for (int i = 0; i < 300; i++) begin
      in_sel = (i % 2 == 0) ? 3'd6 : 3'd7;
      out_ack = (i == 10) ? 8'hFF : 8'h00;
      #1 if (in_ready !== 1'b1) ready_bad++;
      tick();
      if (i == 99) check("drop_100", 128'(drop_count), 128'd100);
    end
    in_valid = 1'b0; out_ack = 8'h00;
    check("disc_ready_all", 128'(ready_bad), 128'h0);
    check("disc_valid", 128'(out_valid), 128'h0);
    check("disc_drop_sat", 128'(drop_count), 128'd255);
    check("disc_data", out_data, {80'h0, 16'h1234, 32'h0});

    // Parallel traffic
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_sel = 3'(k); in_data = 16'(k);
      tick();
    end
    in_valid = 1'b0;
    check("fill_valid", 128'(out_valid), 128'h3F);
    check("fill_data", out_data, {32'h0, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1, 16'h0});
    in_valid = 1'b1; in_sel = 3'd3; in_data = 16'hAAAA; out_ack = 8'b0010_1010;
    #1 check("par_ready", 128'(in_ready), 128'h1);
    tick();
    in_valid = 1'b0; out_ack = 8'h00;
    check("par_valid", 128'(out_valid), 128'h1D);
    check("par_data", out_data, {32'h0, 16'h5, 16'h4, 16'hAAAA, 16'h2, 16'h1, 16'h0});
    check("par_drop", 128'(drop_count), 128'd255);

    // Refill 1 and 5, then async reset between edges
    in_valid = 1'b1; in_sel = 3'd1; in_data = 16'h0011;
    tick();
    in_sel = 3'd5; in_data = 16'h0055;
    tick();
    in_valid = 1'b0;
    check("refill_valid", 128'(out_valid), 128'h3F);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 128'(out_valid), 128'h0);
    check("arst_data",  out_data, 128'h0);
    check("arst_drop",  128'(drop_count), 128'h0);
    #1 reset = 1'b0;
    tick();
    in_valid = 1'b1; in_sel = 3'd2; in_data = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", 128'(out_valid), 128'h04);
    check("post_rst_data",  out_data, {80'h0, 16'hBEEF, 32'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
